// File: rtl/pipe_stage_reg_pkg.sv
// pipe_stage_reg_pkg: shared constants and types for the generic pipeline stage register
package pipe_stage_reg_pkg;
    localparam logic RST_ENABLED = 1'b0;
    localparam logic STOP        = 1'b1;
    localparam logic FLUSH       = 1'b1;
    typedef enum logic [1:0] {OCC_EMPTY, OCC_MAIN, OCC_BOTH} occ_e;
endpackage

// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: valid/ready stage link carrying a data payload and a control payload
interface pipe_stage_reg_if #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 32
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;
    modport master (output valid, data, ctrl, input ready);
    modport slave  (input valid, data, ctrl, output ready);
endinterface

// File: rtl/pipe_sat_counter.sv
// pipe_sat_counter: saturating event counter with synchronous clear
module pipe_sat_counter
    import pipe_stage_reg_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // clear wins over increment; the count sticks at all-ones
    always_comb cnt_d = clr_i ? '0 : (inc_i && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    // count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == RST_ENABLED) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
    assign cnt_o = cnt_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic valid/ready pipeline stage with stall, flush, optional skid and perf counters
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int                 DATA_W   = 64,
    parameter int                 CTRL_W   = 32,
    parameter logic [CTRL_W-1:0]  CTRL_NOP = '0,
    parameter bit                 SKID     = 1'b0,
    parameter int                 CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    pipe_stage_reg_if.slave   in_if,
    pipe_stage_reg_if.master  out_if,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              cnt_clr_i,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);
    logic              in_hs, out_hs;
    logic              main_v_q, main_v_d;
    logic [DATA_W-1:0] main_d_q, main_d_d;
    logic [CTRL_W-1:0] main_c_q, main_c_d;

    assign in_hs  = in_if.valid & in_if.ready;
    assign out_hs = out_if.valid & out_if.ready;

    generate
        if (SKID == 1'b0) begin : g_single
            assign in_if.ready = (stall_i != STOP) & (flush_i != FLUSH) & (out_if.ready | ~main_v_q);
            // single entry: load on input, bubble when drained with nothing behind it
            always_comb begin
                main_v_d = main_v_q;
                main_d_d = main_d_q;
                main_c_d = main_c_q;
                if (flush_i == FLUSH || (out_hs && !in_hs)) begin
                    main_v_d = 1'b0;
                    main_c_d = CTRL_NOP;
                end else if (in_hs) begin
                    main_v_d = 1'b1;
                    main_d_d = in_if.data;
                    main_c_d = in_if.ctrl;
                end
            end
        end else begin : g_skid
            occ_e              occ_q, occ_d;
            logic [DATA_W-1:0] skid_d_q, skid_d_d;
            logic [CTRL_W-1:0] skid_c_q, skid_c_d;
            // ready depends only on registered occupancy and hazard inputs, never on out_ready
            assign in_if.ready = (occ_q != OCC_BOTH) & (stall_i != STOP) & (flush_i != FLUSH);
            // occupancy FSM: skid fills only behind a stuck main entry and refills main first
            always_comb begin
                occ_d    = occ_q;
                main_d_d = main_d_q;
                main_c_d = main_c_q;
                skid_d_d = skid_d_q;
                skid_c_d = skid_c_q;
                if (flush_i == FLUSH) begin
                    occ_d    = OCC_EMPTY;
                    main_c_d = CTRL_NOP;
                end else begin
                    case (occ_q)
                        OCC_EMPTY: if (in_hs) begin
                            main_d_d = in_if.data;
                            main_c_d = in_if.ctrl;
                            occ_d    = OCC_MAIN;
                        end
                        OCC_MAIN: if (out_hs && in_hs) begin
                            main_d_d = in_if.data;
                            main_c_d = in_if.ctrl;
                        end else if (out_hs) begin
                            main_c_d = CTRL_NOP;
                            occ_d    = OCC_EMPTY;
                        end else if (in_hs) begin
                            skid_d_d = in_if.data;
                            skid_c_d = in_if.ctrl;
                            occ_d    = OCC_BOTH;
                        end
                        OCC_BOTH: if (out_hs) begin
                            main_d_d = skid_d_q;
                            main_c_d = skid_c_q;
                            occ_d    = OCC_MAIN;
                        end
                        default: begin
                            occ_d    = OCC_EMPTY;
                            main_c_d = CTRL_NOP;
                        end
                    endcase
                end
                main_v_d = occ_d != OCC_EMPTY;
            end
            // occupancy and skid payload registers
            always_ff @(posedge clk or negedge rst_n) begin
                if (rst_n == RST_ENABLED) begin
                    occ_q    <= OCC_EMPTY;
                    skid_d_q <= '0;
                    skid_c_q <= CTRL_NOP;
                end else begin
                    occ_q    <= occ_d;
                    skid_d_q <= skid_d_d;
                    skid_c_q <= skid_c_d;
                end
            end
        end
    endgenerate

    // main output entry; data survives bubbles and flushes, control does not
    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == RST_ENABLED) begin
            main_v_q <= 1'b0;
            main_d_q <= '0;
            main_c_q <= CTRL_NOP;
        end else begin
            main_v_q <= main_v_d;
            main_d_q <= main_d_d;
            main_c_q <= main_c_d;
        end
    end

    assign out_if.valid = main_v_q;
    assign out_if.data  = main_d_q;
    assign out_if.ctrl  = main_c_q;

    pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (in_if.valid & ~in_if.ready),
        .clr_i (cnt_clr_i),
        .cnt_o (stall_cnt_o)
    );

    pipe_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (~out_if.valid & out_if.ready),
        .clr_i (cnt_clr_i),
        .cnt_o (bubble_cnt_o)
    );
endmodule
